// File: rtl/fpdiv_pkg.sv
// Shared encodings for the Goldschmidt divider datapath (fpdiv) and its
// sequencing FSM (fpdiv_ctrl).
package fpdiv_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ITER_A = 3'd1,
    ITER_B = 3'd2,
    REM    = 3'd3,
    DONE   = 3'd4
  } state_e;

  // Multiplier operand select (sel_mux4)
  localparam logic [1:0] MUX4_IA_NUM = 2'b00;
  localparam logic [1:0] MUX4_IA_DEN = 2'b01;
  localparam logic [1:0] MUX4_C_NUM  = 2'b10;
  localparam logic [1:0] MUX4_C_DEN  = 2'b11;

  // Scaling factor select (sel_mux3)
  localparam logic [1:0] MUX3_IA  = 2'b00;
  localparam logic [1:0] MUX3_C   = 2'b01;
  localparam logic [1:0] MUX3_REM = 2'b10;

endpackage

// File: rtl/fpdiv_ctrl.sv
// Sequencer for fpdiv: one IA iteration, ITERS-1 C-register iterations
// (each an A-half then a B-half), then a remainder capture and a done pulse.
module fpdiv_ctrl
  import fpdiv_pkg::*;
#(
  parameter int ITERS = 6,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [1:0]       sel_mux4,
  output logic [1:0]       sel_mux3,
  output logic             en_a,
  output logic             en_b,
  output logic             en_rem,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter_idx
);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_ITER_A = ITER_A;
  localparam logic [2:0] ST_ITER_B = ITER_B;
  localparam logic [2:0] ST_REM    = REM;
  localparam logic [2:0] ST_DONE   = DONE;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

  logic [2:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;

  always_comb begin
    state_nxt = ST_IDLE;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = ST_ITER_A;
          cnt_nxt   = '0;
        end
      end
      ST_ITER_A: state_nxt = ST_ITER_B;
      ST_ITER_B: begin
        // >= rather than == keeps cnt saturated even from a corrupted value
        if (cnt >= LAST) begin
          state_nxt = ST_REM;
        end else begin
          state_nxt = ST_ITER_A;
          cnt_nxt   = cnt + CNT_W'(1);
        end
      end
      ST_REM:  state_nxt = ST_DONE;
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Moore decode: registered state and cnt only
  always_comb begin
    sel_mux4 = MUX4_IA_NUM;
    sel_mux3 = MUX3_IA;
    en_a     = 1'b0;
    en_b     = 1'b0;
    en_rem   = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    iter_idx = '0;
    case (state)
      ST_ITER_A: begin
        sel_mux4 = (cnt == '0) ? MUX4_IA_NUM : MUX4_C_NUM;
        sel_mux3 = (cnt == '0) ? MUX3_IA : MUX3_C;
        en_a     = 1'b1;
        busy     = 1'b1;
        iter_idx = cnt;
      end
      ST_ITER_B: begin
        sel_mux4 = (cnt == '0) ? MUX4_IA_DEN : MUX4_C_DEN;
        sel_mux3 = (cnt == '0) ? MUX3_IA : MUX3_C;
        en_b     = 1'b1;
        busy     = 1'b1;
        iter_idx = cnt;
      end
      ST_REM: begin
        sel_mux4 = MUX4_C_NUM;
        sel_mux3 = MUX3_REM;
        en_rem   = 1'b1;
        busy     = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fpdiv_ctrl.sv
// Directed plus randomized bench for fpdiv_ctrl (ITERS=6 and ITERS=1 builds
// driven in lockstep) against a cycle-position reference model.
module tb_fpdiv_ctrl;

  logic       clk = 1'b0;
  logic       reset, start;
  logic [1:0] s4_6, s3_6, s4_1, s3_1;
  logic       a6, b6, r6, bz6, d6, a1, b1, r1, bz1, d1;
  logic [3:0] ix6, ix1;

  int ntot = 0, npass = 0, cyc = 0;
  int pos6 = 0, pos1 = 0;
  int busy6_cnt, busy1_cnt;
  int done6_q[$];

  always #5 clk = ~clk;

  fpdiv_ctrl #(.ITERS(6), .CNT_W(4)) dut6 (
    .clk(clk), .reset(reset), .start(start),
    .sel_mux4(s4_6), .sel_mux3(s3_6), .en_a(a6), .en_b(b6), .en_rem(r6),
    .busy(bz6), .done(d6), .iter_idx(ix6));

  fpdiv_ctrl #(.ITERS(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .start(start),
    .sel_mux4(s4_1), .sel_mux3(s3_1), .en_a(a1), .en_b(b1), .en_rem(r1),
    .busy(bz1), .done(d1), .iter_idx(ix1));

  // pos: 0 idle, 1..2n iteration halves (odd = A, even = B), 2n+1 rem, 2n+2 done
  function automatic int next_pos(int pos, int n, logic s, logic r);
    if (!r) return 0;
    if (pos == 0 || pos == 2*n+2) return s ? 1 : 0;
    return pos + 1;
  endfunction

  function automatic logic [12:0] exp_out(int pos, int n);
    logic [1:0] s4, s3;
    logic a, b, rm, bz, d;
    logic [3:0] idx;
    int it;
    s4 = 2'b00; s3 = 2'b00; a = 0; b = 0; rm = 0; bz = 0; d = 0; idx = 0;
    it = (pos - 1) / 2;
    if (pos >= 1 && pos <= 2*n) begin
      bz  = 1;
      idx = it[3:0];
      s3  = (it == 0) ? 2'b00 : 2'b01;
      if (pos % 2 == 1) begin a = 1; s4 = (it == 0) ? 2'b00 : 2'b10; end
      else              begin b = 1; s4 = (it == 0) ? 2'b01 : 2'b11; end
    end else if (pos == 2*n+1) begin
      s4 = 2'b10; s3 = 2'b10; rm = 1; bz = 1;
    end else if (pos == 2*n+2) begin
      d = 1;
    end
    return {s4, s3, a, b, rm, bz, d, idx};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
  endtask

  // Drive inputs, take one edge, advance the model, compare at the falling edge.
  task automatic step(input logic s, input logic r);
    start = s; reset = r;
    @(posedge clk);
    pos6 = next_pos(pos6, 6, s, r);
    pos1 = next_pos(pos1, 1, s, r);
    @(negedge clk);
    cyc++;
    check("outs_it6", {19'd0, s4_6, s3_6, a6, b6, r6, bz6, d6, ix6}, {19'd0, exp_out(pos6, 6)});
    check("outs_it1", {19'd0, s4_1, s3_1, a1, b1, r1, bz1, d1, ix1}, {19'd0, exp_out(pos1, 1)});
    check("enables_onehot0", {31'd0, $onehot0({a6, b6, r6})}, 32'd1);
    if (bz6) busy6_cnt++;
    if (bz1) busy1_cnt++;
    if (d6) done6_q.push_back(cyc);
  endtask

  initial begin
    int t0;
    start = 0; reset = 0;
    @(negedge clk);

    // reset held two cycles, then idle with start low
    step(0, 0); step(0, 0);
    check("reset_state", {19'd0, s4_6, s3_6, a6, b6, r6, bz6, d6, ix6}, 32'd0);
    for (int i = 0; i < 5; i++) step(0, 1);
    check("idle_busy", {31'd0, bz6}, 32'd0);

    // nominal single run: 13 busy cycles, done 13 observations after the first
    busy6_cnt = 0; busy1_cnt = 0; done6_q.delete();
    step(1, 1); t0 = cyc;
    for (int i = 0; i < 16; i++) step(0, 1);
    check("nom_busy_cycles", busy6_cnt, 13);
    check("nom_it1_busy_cycles", busy1_cnt, 3);
    check("nom_done_count", done6_q.size(), 1);
    if (done6_q.size() > 0) check("nom_done_latency", done6_q[0] - t0, 13);

    // start re-pulsed mid-division is ignored
    busy6_cnt = 0; done6_q.delete();
    step(1, 1); t0 = cyc;
    for (int i = 0; i < 5; i++) step(0, 1);
    step(1, 1);
    for (int i = 0; i < 10; i++) step(0, 1);
    check("busy_ign_cycles", busy6_cnt, 13);
    check("busy_ign_done_count", done6_q.size(), 1);
    if (done6_q.size() > 0) check("busy_ign_done_latency", done6_q[0] - t0, 13);

    // back-to-back: start held high through DONE
    done6_q.delete();
    for (int i = 0; i < 32; i++) step(1, 1);
    check("b2b_done_count", done6_q.size(), 2);
    if (done6_q.size() >= 2) check("b2b_done_gap", done6_q[1] - done6_q[0], 14);
    for (int i = 0; i < 16; i++) step(0, 1);

    // reset during ITER_B at cnt=2
    step(1, 1);
    for (int i = 0; i < 5; i++) step(0, 1);
    check("pre_abort_iter_b", {27'd0, b6, ix6}, {27'd0, 1'b1, 4'd2});
    step(0, 0);
    check("abort_idle", {19'd0, s4_6, s3_6, a6, b6, r6, bz6, d6, ix6}, 32'd0);
    busy6_cnt = 0; done6_q.delete();
    step(1, 1); t0 = cyc;
    for (int i = 0; i < 15; i++) step(0, 1);
    check("post_abort_busy", busy6_cnt, 13);
    if (done6_q.size() > 0) check("post_abort_done_latency", done6_q[0] - t0, 13);
    else check("post_abort_done_seen", 0, 1);

    // randomized start/reset traffic
    for (int i = 0; i < 600; i++)
      step(($urandom % 4) == 0, ($urandom % 60) != 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
